// File: rtl/alu_flag_skid_stage.sv
// alu_flag_skid_stage: EX->MEM boundary stage.
// Holds ALU results in a 2-entry skid FIFO. The head result feeds an OR_GATE
// to form the zero flag. When a flag-writing entry leaves the stage, its
// Z/N/C/V flags are committed to the architectural status register.
// Optional feature macro: ALU_PARITY_FLAG_EN adds out_parity and a P bit to
// status_flags, making it {Z,N,C,V,P}.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. in_ready depends only on the occupancy register, and
// out_valid and the head fields come only from registers. No combinational
// path exists from in_* to out_*.

// 8-bit OR reduction cell that derives the zero flag.
module OR_GATE (
  input  logic [7:0] in_i,
  output logic       out_o
);
  // Asserted when any bit of the operand is set.
  assign out_o = |in_i;
endmodule

module alu_flag_skid_stage #(
  parameter int DATA_W = 8,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_ovf,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wb_en,
  input  logic              in_flag_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wb_en,
  output logic              out_zero,
  output logic              out_neg,
`ifdef ALU_PARITY_FLAG_EN
  output logic              out_parity,
  output logic [4:0]        status_flags
`else
  output logic [3:0]        status_flags
`endif
);

`ifdef ALU_PARITY_FLAG_EN
  localparam int SF_W = 5;
`else
  localparam int SF_W = 4;
`endif

  // Entry payload storage; the entries are indexed by the 1-bit pointers.
  logic [DATA_W-1:0] res_q [2];
  logic [RD_W-1:0]   rd_q  [2];
  logic [1:0]        carry_q;
  logic [1:0]        ovf_q;
  logic [1:0]        wb_q;
  logic [1:0]        fwe_q;

  // Control state.
  logic [1:0]      count_q, count_d;
  logic            wp_q, wp_d;
  logic            rp_q, rp_d;
  logic [SF_W-1:0] status_q, status_d;

  logic            push;
  logic            pop;
  logic            or_any;
  logic [SF_W-1:0] head_flags;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // The head fields are zeroed while empty so stale payload never leaks out.
  always_comb begin
    out_result = '0;
    out_rd     = '0;
    out_wb_en  = 1'b0;
    if (out_valid) begin
      out_result = res_q[rp_q];
      out_rd     = rd_q[rp_q];
      out_wb_en  = wb_q[rp_q];
    end
  end

  OR_GATE u_or_gate (
    .in_i  (out_result),
    .out_o (or_any)
  );

  // out_result is already zero when empty, so zero must be masked by valid.
  assign out_zero = out_valid & ~or_any;
  assign out_neg  = out_result[DATA_W-1];

`ifdef ALU_PARITY_FLAG_EN
  assign out_parity = ^out_result;
  assign head_flags = {out_zero, out_neg, carry_q[rp_q], ovf_q[rp_q], out_parity};
`else
  assign head_flags = {out_zero, out_neg, carry_q[rp_q], ovf_q[rp_q]};
`endif

  assign status_flags = status_q;

  // Next-state logic: a flush discards everything and suppresses any commit.
  always_comb begin
    count_d  = count_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    status_d = status_q;
    if (flush) begin
      count_d = 2'd0;
      wp_d    = 1'b0;
      rp_d    = 1'b0;
    end else begin
      if (push) wp_d = ~wp_q;
      if (pop)  rp_d = ~rp_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      if (pop && fwe_q[rp_q]) status_d = head_flags;
    end
  end

  // Control register update; reset outranks flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      status_q <= '0;
    end else begin
      count_q  <= count_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      status_q <= status_d;
    end
  end

  // Payload capture; it needs no reset because invalid slots are never shown.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      res_q[wp_q]   <= in_result;
      rd_q[wp_q]    <= in_rd;
      carry_q[wp_q] <= in_carry;
      ovf_q[wp_q]   <= in_ovf;
      wb_q[wp_q]    <= in_wb_en;
      fwe_q[wp_q]   <= in_flag_we;
    end
  end

endmodule

// File: tb/tb_alu_flag_skid_stage.sv
// Bench for alu_flag_skid_stage: a directed vector table with hand-derived
// expectations, followed by randomized traffic checked against a queue model.
module tb_alu_flag_skid_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flush, in_valid, in_ready;
  logic [7:0] in_result;
  logic       in_carry, in_ovf;
  logic [2:0] in_rd;
  logic       in_wb_en, in_flag_we;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic [2:0] out_rd;
  logic       out_wb_en, out_zero, out_neg;
`ifdef ALU_PARITY_FLAG_EN
  logic       out_parity;
  logic [4:0] status_flags;
  localparam logic [4:0] STAT_MASK = 5'b11111;
  localparam logic       PAR_EN    = 1'b1;
`else
  logic [3:0] status_flags;
  localparam logic [4:0] STAT_MASK = 5'b11110;
  localparam logic       PAR_EN    = 1'b0;
`endif

  alu_flag_skid_stage #(.DATA_W(8), .RD_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_ovf       (in_ovf),
    .in_rd        (in_rd),
    .in_wb_en     (in_wb_en),
    .in_flag_we   (in_flag_we),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_wb_en    (out_wb_en),
    .out_zero     (out_zero),
    .out_neg      (out_neg),
`ifdef ALU_PARITY_FLAG_EN
    .out_parity   (out_parity),
`endif
    .status_flags (status_flags)
  );

  // Status widened to {Z,N,C,V,P}; P reads as 0 when the feature is absent.
  function automatic logic [4:0] dut_stat5();
`ifdef ALU_PARITY_FLAG_EN
    return status_flags;
`else
    return {status_flags, 1'b0};
`endif
  endfunction

  function automatic logic dut_par();
`ifdef ALU_PARITY_FLAG_EN
    return out_parity;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Entry packing: {result[7:0], carry, ovf, rd[2:0], wb_en, flag_we}.
  logic [14:0] exp_q[$];
  logic [4:0]  m_stat = '0;
  logic        last_push;

  function automatic logic [21:0] model_vec();
    logic [14:0] h;
    logic        v;
    logic [7:0]  r;
    v = (exp_q.size() != 0);
    h = v ? exp_q[0] : 15'd0;
    r = h[14:7];
    return {exp_q.size() < 2, v, r, h[4:2], h[1], v && (r == 8'h00), r[7],
            (^r) & PAR_EN, m_stat & STAT_MASK};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {in_ready, out_valid, out_result, out_rd, out_wb_en, out_zero, out_neg,
            dut_par(), dut_stat5() & STAT_MASK};
  endfunction

  typedef struct packed {
    logic       rst, fl, vld, rdy;
    logic [7:0] res;
    logic       c, o;
    logic [2:0] rd;
    logic       wb, fwe;
    logic       ev, er;
    logic [7:0] eres;
    logic       ez, en, ep;
    logic [4:0] est;
  } vec_t;

  // ---------------- driver ----------------
  task automatic step(input vec_t t, input string name);
    logic        do_pop, do_push;
    logic [14:0] h;
    rst_n      = t.rst;
    flush      = t.fl;
    in_valid   = t.vld;
    out_ready  = t.rdy;
    in_result  = t.res;
    in_carry   = t.c;
    in_ovf     = t.o;
    in_rd      = t.rd;
    in_wb_en   = t.wb;
    in_flag_we = t.fwe;
    @(posedge clk);
    last_push = 1'b0;
    if (!t.rst) begin
      exp_q.delete();
      m_stat = '0;
    end else if (t.fl) begin
      exp_q.delete();
    end else begin
      do_pop  = (exp_q.size() != 0) && t.rdy;
      do_push = t.vld && (exp_q.size() < 2);
      if (do_pop) begin
        h = exp_q.pop_front();
        if (h[0]) m_stat = {h[14:7] == 8'h00, h[14], h[6], h[5], ^h[14:7]};
      end
      if (do_push) begin
        exp_q.push_back({t.res, t.c, t.o, t.rd, t.wb, t.fwe});
        last_push = 1'b1;
      end
    end
    #1;
    chk({name, " model"}, 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic check_row(input vec_t t, input int i);
    chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(t.ev));
    chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(t.er));
    chk($sformatf("row%0d out_result", i), 32'(out_result), 32'(t.eres));
    chk($sformatf("row%0d out_zero", i), 32'(out_zero), 32'(t.ez));
    chk($sformatf("row%0d out_neg", i), 32'(out_neg), 32'(t.en));
    chk($sformatf("row%0d status", i), 32'(dut_stat5() & STAT_MASK), 32'(t.est & STAT_MASK));
`ifdef ALU_PARITY_FLAG_EN
    chk($sformatf("row%0d out_parity", i), 32'(out_parity), 32'(t.ep));
`endif
  endtask

  // Runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  vec_t tbl[23];
  vec_t r;
  logic hold;

  initial begin
    // rst fl vld rdy res c o rd wb fwe | ev er eres ez en ep est{Z,N,C,V,P}
    tbl[0]  = '{'0,'0,'0,'0,8'h00,'0,'0,3'd0,'0,'0, '0,'1,8'h00,'0,'0,'0,5'b00000};
    tbl[1]  = '{'1,'0,'1,'1,8'h00,'1,'0,3'd1,'1,'1, '1,'1,8'h00,'1,'0,'0,5'b00000};
    tbl[2]  = '{'1,'0,'0,'1,8'h00,'0,'0,3'd0,'0,'0, '0,'1,8'h00,'0,'0,'0,5'b10100};
    tbl[3]  = '{'1,'0,'1,'0,8'h81,'0,'0,3'd2,'1,'0, '1,'1,8'h81,'0,'1,'0,5'b10100};
    tbl[4]  = '{'1,'0,'1,'0,8'h05,'0,'1,3'd3,'0,'1, '1,'0,8'h81,'0,'1,'0,5'b10100};
    tbl[5]  = '{'1,'0,'1,'0,8'h99,'1,'1,3'd4,'1,'1, '1,'0,8'h81,'0,'1,'0,5'b10100};
    tbl[6]  = '{'1,'0,'0,'1,8'h00,'0,'0,3'd0,'0,'0, '1,'1,8'h05,'0,'0,'0,5'b10100};
    tbl[7]  = '{'1,'0,'0,'1,8'h00,'0,'0,3'd0,'0,'0, '0,'1,8'h00,'0,'0,'0,5'b00010};
    tbl[8]  = '{'1,'0,'1,'0,8'h00,'1,'1,3'd5,'1,'0, '1,'1,8'h00,'1,'0,'0,5'b00010};
    tbl[9]  = '{'1,'0,'0,'1,8'h00,'0,'0,3'd0,'0,'0, '0,'1,8'h00,'0,'0,'0,5'b00010};
    tbl[10] = '{'1,'0,'1,'0,8'h10,'1,'1,3'd6,'1,'1, '1,'1,8'h10,'0,'0,'1,5'b00010};
    tbl[11] = '{'1,'0,'1,'1,8'h20,'0,'0,3'd7,'1,'1, '1,'1,8'h20,'0,'0,'1,5'b00111};
    tbl[12] = '{'1,'0,'1,'0,8'h44,'0,'0,3'd1,'0,'0, '1,'0,8'h20,'0,'0,'1,5'b00111};
    tbl[13] = '{'1,'1,'1,'1,8'h33,'1,'1,3'd2,'1,'1, '0,'1,8'h00,'0,'0,'0,5'b00111};
    tbl[14] = '{'1,'0,'0,'1,8'h00,'0,'0,3'd0,'0,'0, '0,'1,8'h00,'0,'0,'0,5'b00111};
    tbl[15] = '{'1,'0,'1,'1,8'h55,'0,'0,3'd3,'1,'0, '1,'1,8'h55,'0,'0,'0,5'b00111};
    tbl[16] = '{'1,'1,'1,'1,8'h66,'0,'0,3'd4,'1,'1, '0,'1,8'h00,'0,'0,'0,5'b00111};
    tbl[17] = '{'1,'0,'1,'1,8'h07,'1,'0,3'd5,'1,'1, '1,'1,8'h07,'0,'0,'1,5'b00111};
    tbl[18] = '{'1,'0,'0,'1,8'h00,'0,'0,3'd0,'0,'0, '0,'1,8'h00,'0,'0,'0,5'b00101};
    tbl[19] = '{'1,'0,'1,'0,8'h8F,'1,'1,3'd6,'1,'1, '1,'1,8'h8F,'0,'1,'1,5'b00101};
    tbl[20] = '{'1,'0,'1,'0,8'h01,'0,'0,3'd7,'1,'1, '1,'0,8'h8F,'0,'1,'1,5'b00101};
    tbl[21] = '{'0,'1,'1,'1,8'h22,'1,'1,3'd1,'1,'1, '0,'1,8'h00,'0,'0,'0,5'b00000};
    tbl[22] = '{'1,'0,'0,'0,8'h00,'0,'0,3'd0,'0,'0, '0,'1,8'h00,'0,'0,'0,5'b00000};

    for (int i = 0; i < 23; i++) begin
      step(tbl[i], $sformatf("row%0d", i));
      check_row(tbl[i], i);
    end

    // Randomized traffic; an unaccepted entry is held stable until taken.
    r    = '0;
    hold = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!hold) begin
        r.vld = 1'($urandom_range(0, 1));
        r.res = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        r.c   = 1'($urandom_range(0, 1));
        r.o   = 1'($urandom_range(0, 1));
        r.rd  = 3'($urandom_range(0, 7));
        r.wb  = 1'($urandom_range(0, 1));
        r.fwe = 1'($urandom_range(0, 1));
      end
      r.rst = ($urandom_range(0, 49) != 0);
      r.fl  = ($urandom_range(0, 15) == 0);
      r.rdy = ($urandom_range(0, 2) != 0);
      step(r, $sformatf("rand%0d", k));
      hold = r.vld && !last_push;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_flag_skid_stage.md
Name: alu_flag_skid_stage

Overview:
- EX→MEM boundary stage sitting directly upstream of the 8-bit OR reduction gate (OR_GATE).
- Buffers ALU results in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Drives the head entry's result into an OR_GATE instance to derive the zero flag.
- Commits Z/N/C/V to an architectural status register when an entry with flag-write set leaves the stage.

Parameters:
- DATA_W, 8, result width; the OR_GATE instance requires 8.
- RD_W, 3, destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_result  in  DATA_W  ALU result.
- in_carry  in  1  ALU carry-out.
- in_ovf  in  1  ALU signed overflow.
- in_rd  in  RD_W  destination register.
- in_wb_en  in  1  writeback enable.
- in_flag_we  in  1  entry updates status flags.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_result  out  DATA_W  head result.
- out_rd  out  RD_W  head destination register.
- out_wb_en  out  1  head writeback enable.
- out_zero  out  1  ~OR_GATE(out_result).
- out_neg  out  1  out_result[7].
- status_flags  out  4  committed {Z,N,C,V}.

Behaviour:
- Storage: 2 entries, each holding {result, carry, ovf, rd, wb_en, flag_we}.
  - Write pointer wp and read pointer rp are 1 bit each; occupancy count is 0..2.
  - Entries are consumed in arrival order.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != 2), decoded combinationally from the count register.
- out_valid = (count != 0). Head fields come from entry[rp].
- Latency: an entry pushed at edge N is visible on the outputs after edge N (one cycle). No combinational path from in_* to out_*.
- out_zero:
  - Computed combinationally as the inverse of an instantiated OR_GATE driven by out_result.
  - Forced to 0 when out_valid=0.
- out_neg = out_result[7] when valid, else 0.
- Count update per edge:
  - push only: +1.
  - pop only: -1.
  - push & pop with count==1: unchanged; wp and rp both advance.
  - push & pop with count==0: impossible, since pop requires valid.
- Status commit: on a pop whose head flag_we=1, status_flags <= {out_zero, out_neg, head carry, head ovf}.
- A pop with flag_we=0 leaves status_flags unchanged.
- Flush:
  - Next edge: count=0, wp=rp=0.
  - Flush has priority over a simultaneous push and pop. The pushed entry is dropped, and a popped head does NOT commit flags.
  - status_flags is retained.
- Reset (rst_n=0 at edge):
  - count=0, wp=rp=0, status_flags=4'b0000.
  - out_valid=0, out_zero=0, out_neg=0.
  - Entry payload is don't-care but must not reach outputs while invalid.
  - in_ready=1 from the first edge after reset deasserts.
  - Reset mid-stream discards all entries and takes priority over flush.
- out_result, out_rd and out_wb_en drive 0 when out_valid=0.
- Upstream must hold in_* stable while in_valid & ~in_ready.

Optional Feature:
- Macro: ALU_PARITY_FLAG_EN.
- Defined:
  - Adds output out_parity (1 bit) = even parity (XOR reduction) of out_result, 0 when invalid.
  - status_flags widens to 5 bits {Z,N,C,V,P}; P is committed under the same rules as the other flags.
  - Reset value is 5'b00000.
- Undefined: no parity logic or port; status_flags is 4 bits.

Test Plan:
- Reset then push result=0x00, carry=1, ovf=0, flag_we=1 with out_ready=1 → out_valid one cycle later, out_zero=1, out_neg=0; after the pop, status_flags=4'b1010.
- out_ready=0, push 0x81 then 0x05 → in_ready=0 after the second push, count=2. A third in_valid is not accepted. Raising out_ready pops 0x81 (neg=1, zero=0) then 0x05, in order.
- count=1 (head 0x10), simultaneous push 0x20 and pop → count stays 1, next head=0x20, no bubble on out_valid.
- Pop an entry with flag_we=0 and result 0x00 → status_flags unchanged from its prior value (e.g. stays 4'b0001).
- Two entries buffered and flush asserted together with a push of 0x33 and a pop → next cycle out_valid=0, in_ready=1, status_flags unchanged, 0x33 never appears.
- With ALU_PARITY_FLAG_EN: pop result=0x07 with flag_we=1 → out_parity=1 and status_flags[0]=1. rst_n low mid-stream → status_flags=5'b00000 and out_valid=0 next cycle.
